// File: rtl/dcache_refill_engine.sv
// Data-cache line refill engine: optional dirty-victim write-back, then word-by-word line fetch.
// Latency: done pulse 1+LINE_WORDS cycles (clean) or 1+2*LINE_WORDS cycles (dirty) after accept with ack held high.
// Backpressure: each word's address/data is held until mem_ack_i; busy_o stalls the pipeline from the miss cycle through DONE.
module dcache_refill_engine #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     miss_req_i,
    input  logic [ADDR_W-1:0]        miss_addr_i,
    input  logic                     dirty_i,
    input  logic [ADDR_W-1:0]        victim_addr_i,
    input  logic [32*LINE_WORDS-1:0] victim_data_i,
    output logic [32*LINE_WORDS-1:0] refill_data_o,
    output logic                     refill_done_o,
    output logic                     busy_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [31:0]              mem_wdata_o,
    input  logic                     mem_ack_i,
    input  logic [31:0]              mem_rdata_i,
    output logic [31:0]              refill_cnt_o,
    output logic [31:0]              wb_cnt_o
);

    localparam int WCNT_W = $clog2(LINE_WORDS);
    localparam int LOW_W  = WCNT_W + 2;
    localparam int LINE_W = 32 * LINE_WORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RF   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [WCNT_W-1:0]   wcnt, wcnt_nxt;
    logic [ADDR_W-1:0]   miss_base, victim_base;
    logic [LINE_W-1:0]   victim_line;
    logic                last_word;
    logic                accept;
    logic                unused_addr_bits;

    assign last_word = (wcnt == WCNT_W'(LINE_WORDS - 1));
    assign accept    = (state == IDLE) && miss_req_i;

    // Byte/word offset bits are dropped when the line base is captured.
    assign unused_addr_bits = ^{miss_addr_i[LOW_W-1:0], victim_addr_i[LOW_W-1:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        wcnt_nxt      = wcnt;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        refill_done_o = 1'b0;
        busy_o        = 1'b1;
        case (state)
            IDLE: begin
                busy_o = miss_req_i;
                if (miss_req_i) begin
                    wcnt_nxt  = '0;
                    state_nxt = dirty_i ? WB : RF;
                end
            end
            WB: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = victim_base + ADDR_W'({wcnt, 2'b00});
                mem_wdata_o = victim_line[32*wcnt +: 32];
                if (mem_ack_i) begin
                    wcnt_nxt = wcnt + 1'b1;
                    if (last_word) begin
                        state_nxt = RF;
                    end
                end
            end
            RF: begin
                mem_req_o  = 1'b1;
                mem_addr_o = miss_base + ADDR_W'({wcnt, 2'b00});
                if (mem_ack_i) begin
                    wcnt_nxt = wcnt + 1'b1;
                    if (last_word) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                refill_done_o = 1'b1;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Keep the stall low while held in reset, even with a miss pending.
        if (rst_i) begin
            busy_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            miss_base     <= '0;
            victim_base   <= '0;
            victim_line   <= '0;
            refill_data_o <= '0;
            refill_cnt_o  <= '0;
            wb_cnt_o      <= '0;
        end else begin
            if (accept) begin
                miss_base   <= {miss_addr_i[ADDR_W-1:LOW_W], {LOW_W{1'b0}}};
                victim_base <= {victim_addr_i[ADDR_W-1:LOW_W], {LOW_W{1'b0}}};
                victim_line <= victim_data_i;
            end
            if (state == RF && mem_ack_i) begin
                refill_data_o[32*wcnt +: 32] <= mem_rdata_i;
            end
            if (state == WB && mem_ack_i && last_word) begin
                wb_cnt_o <= wb_cnt_o + 32'd1;
            end
            if (state == DONE) begin
                refill_cnt_o <= refill_cnt_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_refill_engine.sv
// Directed bench for dcache_refill_engine: table of miss scenarios plus reset, spurious-input and back-to-back sequences.
module tb_dcache_refill_engine;

    logic         clk;
    logic         rst;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         dirty;
    logic [31:0]  victim_addr;
    logic [127:0] victim_data;
    logic [127:0] refill_data;
    logic         refill_done;
    logic         busy;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic [31:0]  refill_cnt;
    logic [31:0]  wb_cnt;

    dcache_refill_engine #(.LINE_WORDS(4), .ADDR_W(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .miss_req_i    (miss_req),
        .miss_addr_i   (miss_addr),
        .dirty_i       (dirty),
        .victim_addr_i (victim_addr),
        .victim_data_i (victim_data),
        .refill_data_o (refill_data),
        .refill_done_o (refill_done),
        .busy_o        (busy),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_ack_i     (mem_ack),
        .mem_rdata_i   (mem_rdata),
        .refill_cnt_o  (refill_cnt),
        .wb_cnt_o      (wb_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory returns the word address as data.
    assign mem_rdata = mem_addr;

    int ack_every = 1;
    bit spurious_ack = 1'b0;
    int ack_wait = 0;

    initial begin
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!mem_req) begin
                ack_wait = 0;
                mem_ack  = spurious_ack;
            end else begin
                ack_wait++;
                if (ack_wait >= ack_every) begin
                    mem_ack  = 1'b1;
                    ack_wait = 0;
                end else begin
                    mem_ack = 1'b0;
                end
            end
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       xlog[$];
    int          stable_err = 0;
    int          done_cnt = 0;
    bit          pend = 1'b0;
    logic [64:0] pend_val;

    // Transfer monitor: logs accepted words and flags any change of an unacked request.
    always @(negedge clk) begin
        #1;
        if (refill_done) done_cnt++;
        if (!rst && mem_req) begin
            if (pend && pend_val !== {mem_we, mem_addr, mem_wdata}) stable_err++;
            pend     = !mem_ack;
            pend_val = {mem_we, mem_addr, mem_wdata};
            if (mem_ack) xlog.push_back('{mem_we, mem_addr, mem_wdata});
        end else begin
            pend = 1'b0;
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Waits for the done pulse; n is the cycle it was seen in, counted from the accept edge.
    task automatic wait_done(output int n, output int drop);
        bit found;
        found = 1'b0;
        n     = 0;
        drop  = 0;
        while (!found && n < 300) begin
            @(negedge clk);
            #1;
            n++;
            if (!busy) drop++;
            if (refill_done) found = 1'b1;
        end
    endtask

    typedef struct {
        logic [31:0]  miss_addr;
        logic         dirty;
        logic [31:0]  victim_addr;
        logic [127:0] victim_data;
        int           ack_every;
        logic [31:0]  exp_rd_base;
        logic [31:0]  exp_wb_base;
        int           exp_lat;
        logic [127:0] exp_line;
        logic [31:0]  exp_refill_cnt;
        logic [31:0]  exp_wb_cnt;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int           n;
        int           drop;
        int           nw;
        int           off;
        logic [127:0] vd;
        string        tag;
        tag = $sformatf("v%0d", idx);
        xlog.delete();
        stable_err = 0;
        ack_every  = v.ack_every;
        vd         = v.victim_data;
        @(negedge clk);
        miss_addr   = v.miss_addr;
        dirty       = v.dirty;
        victim_addr = v.victim_addr;
        victim_data = v.victim_data;
        miss_req    = 1'b1;
        #1 chk({tag, "_busy_on_miss"}, busy, 1);
        @(posedge clk);
        #1;
        // Captured inputs must be ignored from here on.
        miss_req    = 1'b0;
        miss_addr   = 32'hFFFF_FFFC;
        dirty       = ~v.dirty;
        victim_addr = 32'hEEEE_EEE0;
        victim_data = {4{32'hDEAD_BEEF}};
        wait_done(n, drop);
        chk({tag, "_latency"}, n, v.exp_lat);
        chk({tag, "_busy_drop"}, drop, 0);
        @(negedge clk);
        #1;
        chk({tag, "_busy_idle"}, busy, 0);
        chk({tag, "_done_single"}, refill_done, 0);
        chk({tag, "_req_idle"}, {mem_req, mem_we, mem_addr, mem_wdata}, 0);
        chk({tag, "_line"}, refill_data, v.exp_line);
        chk({tag, "_refill_cnt"}, refill_cnt, v.exp_refill_cnt);
        chk({tag, "_wb_cnt"}, wb_cnt, v.exp_wb_cnt);
        chk({tag, "_stable"}, stable_err, 0);
        off = v.dirty ? 4 : 0;
        nw  = off + 4;
        chk({tag, "_xfer_count"}, xlog.size(), nw);
        for (int i = 0; i < nw && i < xlog.size(); i++) begin
            if (i < off) begin
                chk($sformatf("%s_wb%0d", tag, i), {xlog[i].we, xlog[i].addr, xlog[i].wdata},
                    {1'b1, v.exp_wb_base + 32'(4 * i), vd[32*i +: 32]});
            end else begin
                chk($sformatf("%s_rd%0d", tag, i - off), {xlog[i].we, xlog[i].addr},
                    {1'b0, v.exp_rd_base + 32'(4 * (i - off))});
            end
        end
    endtask

    vec_t vecs[4];

    initial begin
        int n;
        int drop;
        int k;
        int dc0;

        vecs[0] = '{32'h0000_1234, 1'b0, 32'h0, 128'h0, 1, 32'h0000_1230, 32'h0, 5,
                    {32'h123C, 32'h1238, 32'h1234, 32'h1230}, 32'd1, 32'd0};
        vecs[1] = '{32'h0000_3000, 1'b1, 32'h0000_2008,
                    {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0}, 1,
                    32'h0000_3000, 32'h0000_2000, 9,
                    {32'h300C, 32'h3008, 32'h3004, 32'h3000}, 32'd2, 32'd1};
        vecs[2] = '{32'h0000_4F7C, 1'b0, 32'h0, 128'h0, 3, 32'h0000_4F70, 32'h0, 13,
                    {32'h4F7C, 32'h4F78, 32'h4F74, 32'h4F70}, 32'd3, 32'd1};
        vecs[3] = '{32'h0000_6ABE, 1'b1, 32'h0000_5014,
                    {32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hB1B1_B1B1, 32'hB0B0_B0B0}, 3,
                    32'h0000_6AB0, 32'h0000_5010, 25,
                    {32'h6ABC, 32'h6AB8, 32'h6AB4, 32'h6AB0}, 32'd4, 32'd2};

        rst         = 1'b1;
        miss_req    = 1'b0;
        miss_addr   = '0;
        dirty       = 1'b0;
        victim_addr = '0;
        victim_data = '0;
        #1;
        chk("reset_outputs", {refill_done, busy, mem_req, mem_we, mem_addr, mem_wdata}, 0);
        chk("reset_line", refill_data, 0);
        chk("reset_counters", {refill_cnt, wb_cnt}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // Spurious ack in IDLE, then miss_req toggling throughout the refill.
        xlog.delete();
        spurious_ack = 1'b1;
        ack_every    = 3;
        repeat (3) @(negedge clk);
        #1;
        chk("spur_idle_req", {mem_req, busy}, 0);
        chk("spur_idle_xfers", xlog.size(), 0);
        dc0 = done_cnt;
        @(negedge clk);
        miss_addr = 32'h0000_9004;
        dirty     = 1'b0;
        miss_req  = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        k = 0;
        while (!k && n < 300) begin
            @(negedge clk);
            #1;
            n++;
            if (refill_done) k = 1;
            else miss_req = ~miss_req;
        end
        miss_req = 1'b0;
        chk("spur_latency", n, 13);
        repeat (4) @(negedge clk);
        #1;
        chk("spur_done_pulses", done_cnt - dc0, 1);
        chk("spur_xfer_count", xlog.size(), 4);
        if (xlog.size() == 4) begin
            chk("spur_first_rd", {xlog[0].we, xlog[0].addr}, {1'b0, 32'h9000});
            chk("spur_last_rd", {xlog[3].we, xlog[3].addr}, {1'b0, 32'h900C});
        end
        chk("spur_line", refill_data, {32'h900C, 32'h9008, 32'h9004, 32'h9000});
        chk("spur_refill_cnt", refill_cnt, 5);
        spurious_ack = 1'b0;

        // Reset during the second refill word.
        xlog.delete();
        dc0 = done_cnt;
        @(negedge clk);
        miss_addr = 32'h0000_7000;
        miss_req  = 1'b1;
        @(posedge clk);
        #1 miss_req = 1'b0;
        k = 0;
        while (xlog.size() < 1 && k < 100) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("rst_first_word", xlog.size(), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_req_drop", mem_req, 0);
        chk("rst_busy_drop", busy, 0);
        @(negedge clk);
        #1;
        chk("rst_line_clear", refill_data, 0);
        chk("rst_counters", {refill_cnt, wb_cnt}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_no_done", done_cnt - dc0, 0);
        chk("rst_idle", {mem_req, busy}, 0);
        chk("rst_no_more_xfers", xlog.size(), 1);

        // Back-to-back misses with miss_req held across DONE.
        xlog.delete();
        ack_every = 1;
        @(negedge clk);
        miss_addr = 32'h0000_8008;
        dirty     = 1'b0;
        miss_req  = 1'b1;
        @(posedge clk);
        #1;
        wait_done(n, drop);
        chk("b2b_first_latency", n, 5);
        chk("b2b_first_busy", drop, 0);
        wait_done(n, drop);
        miss_req = 1'b0;
        chk("b2b_second_latency", n, 6);
        chk("b2b_second_busy", drop, 0);
        @(negedge clk);
        #1;
        chk("b2b_idle", busy, 0);
        chk("b2b_refill_cnt", refill_cnt, 2);
        chk("b2b_wb_cnt", wb_cnt, 0);
        chk("b2b_xfer_count", xlog.size(), 8);
        if (xlog.size() == 8) begin
            chk("b2b_second_first_rd", xlog[4].addr, 32'h8000);
            chk("b2b_second_last_rd", xlog[7].addr, 32'h800C);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_refill_engine.md
Name: dcache_refill_engine

Overview:
- Line-fill and write-back engine between the data cache (MEM stage) and external word-wide main memory.
- On a dcache miss it writes back the dirty victim line, if there is one, then fetches the missing line one word at a time. It returns the assembled line and drives the pipeline-wide dcache stall.
- It also keeps refill and write-back event counters for performance measurement.

Parameters:
- LINE_WORDS, 4, 32-bit words per cache line (power of two, 2..16).
- ADDR_W, 32, byte address width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- miss_req_i  in  1  cache miss request; sampled only in IDLE.
- miss_addr_i  in  ADDR_W  byte address of the missing access.
- dirty_i  in  1  victim line is dirty.
- victim_addr_i  in  ADDR_W  byte address of the victim line.
- victim_data_i  in  32*LINE_WORDS  victim line; word i at bits [32i+31:32i].
- refill_data_o  out  32*LINE_WORDS  fetched line, same word ordering.
- refill_done_o  out  1  one-cycle pulse when refill_data_o is valid.
- busy_o  out  1  stall request to all pipeline stages.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  ADDR_W  word-aligned memory address.
- mem_wdata_o  out  32  write data.
- mem_ack_i  in  1  memory accepted the word (writes) or returns the word (reads).
- mem_rdata_i  in  32  read data, valid when mem_ack_i is high.
- refill_cnt_o  out  32  number of completed refills, wraps.
- wb_cnt_o  out  32  number of completed write-backs, wraps.

Behaviour:
- States: IDLE, WB, RF, DONE. Word counter wcnt has width clog2(LINE_WORDS).
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, wcnt = 0.
  - All outputs are 0, including refill_data_o and both counters.
  - A reset mid-transfer drops mem_req_o at once; the partial line is discarded and no done pulse is produced.
- IDLE with miss_req_i = 1, on the clock edge:
  - Line-align both addresses: clear the low clog2(LINE_WORDS)+2 bits.
  - Capture the aligned miss address, and the aligned victim address and victim_data_i.
  - Clear wcnt.
  - Go to WB if dirty_i = 1, otherwise to RF.
- busy_o = (state != IDLE) | (state == IDLE & miss_req_i). The stall therefore asserts in the same cycle as the miss and stays high through DONE.
- WB state:
  - mem_req_o = 1, mem_we_o = 1.
  - mem_addr_o = victim base + 4*wcnt; mem_wdata_o = captured victim word wcnt.
  - Address and data stay stable until mem_ack_i = 1. On ack, wcnt increments.
  - mem_req_o may remain high continuously, giving one word per cycle when ack is held high.
  - Ack on the last word: wcnt returns to 0, wb_cnt_o increments, next state is RF.
- RF state:
  - mem_req_o = 1, mem_we_o = 0, mem_addr_o = miss base + 4*wcnt.
  - On mem_ack_i, mem_rdata_i is written into refill_data_o word wcnt and wcnt increments.
  - Ack on the last word: next state is DONE.
- DONE state, exactly one cycle:
  - refill_done_o = 1; refill_cnt_o increments.
  - mem_req_o = 0, busy_o = 1 (the cache writes the line this cycle).
  - Next state is IDLE. A miss_req_i seen in DONE is ignored; the cache re-presents it in IDLE.
- In IDLE and DONE: mem_req_o = 0, and mem_we_o, mem_addr_o and mem_wdata_o are 0.
- refill_data_o holds its value until words are overwritten by the next refill.
- Ignored inputs:
  - mem_ack_i while mem_req_o = 0.
  - miss_req_i outside IDLE.
  - miss_addr_i, dirty_i and the victim inputs after capture, even if they change.
- Latency, with mem_ack_i tied high:
  - clean miss: refill_done_o asserts 1 + LINE_WORDS cycles after the miss is accepted;
  - dirty miss: 1 + 2*LINE_WORDS cycles after the miss is accepted.
- Counters are 32 bits and wrap from 0xFFFFFFFF to 0.

Test Plan:
1. Clean miss: miss_addr 0x0000_1234, dirty 0, ack always high, memory returns word = address -> four reads at 0x1230, 0x1234, 0x1238, 0x123C; done pulse 5 cycles after accept; refill_data = {0x123C, 0x1238, 0x1234, 0x1230}; refill_cnt = 1; wb_cnt = 0.
2. Dirty miss: victim_addr 0x0000_2008, victim words A0..A3, miss 0x0000_3000 -> writes A0..A3 to 0x2000..0x200C, then reads 0x3000..0x300C; busy high from the miss cycle through DONE; wb_cnt = 1; refill_cnt = 1.
3. Ack back-pressure: ack high only every third cycle -> address and data stable while unacked; no word skipped or duplicated; done after 12 cycles of RF.
4. Reset asserted during the second RF word -> mem_req_o and busy_o low immediately; after release, state IDLE, refill_data = 0, counters = 0, no done pulse.
5. Spurious inputs: mem_ack_i high in IDLE, and miss_req_i toggling during RF -> no state change and no extra transfer; exactly one done pulse.
6. Back-to-back misses: miss_req_i held high across DONE -> second miss accepted in the following IDLE cycle; refill_cnt = 2.
